// File: rtl/fifo_word_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_word_serializer_pkg
//  Description : Shared types for the FIFO word serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_word_serializer_pkg;

    // IDLE: no word held. SEND: a word is held and being streamed out.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage : fifo_word_serializer_pkg
`default_nettype wire

// File: rtl/fifo_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_word_serializer
//  Description : Pops words from a show-ahead FIFO and streams each one as
//                width/out_width chunks, LSB chunk first, on valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_word_serializer
    import fifo_word_serializer_pkg::*;
#(
    parameter int width     = 8,
    parameter int out_width = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [width-1:0]     fifo_read_data,
    output logic                 fifo_pop,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [out_width-1:0] out_data,
    output logic                 out_last
);

    localparam int chunks = width / out_width;
    localparam int cnt_w  = (chunks > 1) ? $clog2(chunks) : 1;
    localparam logic [cnt_w-1:0] c_last_cnt = cnt_w'(chunks - 1);

    if ((out_width < 1) || (out_width > width) || ((width % out_width) != 0)) begin : g_bad_params
        $error("fifo_word_serializer: width must be a non-zero multiple of out_width");
    end

    ser_state_t       state_q, state_d;
    logic [cnt_w-1:0] cnt_q,   cnt_d;
    logic [width-1:0] word_q,  word_d;

    logic fire;
    logic is_last;
    int   chunk_base;

    always_comb begin
        out_valid  = (state_q == SEND);
        is_last    = (cnt_q == c_last_cnt);
        out_last   = out_valid & is_last;
        chunk_base = int'(cnt_q) * out_width;
        out_data   = word_q[chunk_base +: out_width];
        fire       = out_valid & out_ready;

        // Refill from the FIFO when idle, or on the final beat so words run back to back.
        fifo_pop = rst & ~fifo_empty & ((state_q == IDLE) | (fire & is_last));

        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;

        if (fifo_pop) begin
            word_d  = fifo_read_data;
            cnt_d   = '0;
            state_d = SEND;
        end else if (fire) begin
            if (is_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

endmodule : fifo_word_serializer
`default_nettype wire
